get_bit: RTL and testbench

Bitstream unpacker for the decode path. It accepts the MSB-first byte stream that the encoder's bit packer emits and returns variable-length fields of 0–32 bits on request. It also supports a byte-align command, the inverse of the packer's flush. It sits between the byte-level stream source and the entropy decoders (Golomb/Rice and header parsers).

---
 rtl/get_bit_if.sv | 25 ++
 rtl/get_bit.sv | 99 +++++++++
 tb/tb_get_bit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/get_bit_if.sv
// Handshake bundle between the byte source, the entropy decoders and get_bit.
// master = stream/request side, slave = the unpacker.
interface get_bit_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        req_valid;
  logic [5:0]  req_size;
  logic        req_ready;
  logic        align;
  logic        rsp_valid;
  logic [31:0] rsp_val;
  logic [6:0]  bit_count;
  logic [31:0] total_byte_size;

  modport master (
    output in_valid, in_byte, req_valid, req_size, align,
    input  in_ready, req_ready, rsp_valid, rsp_val, bit_count, total_byte_size
  );

  modport slave (
    input  in_valid, in_byte, req_valid, req_size, align,
    output in_ready, req_ready, rsp_valid, rsp_val, bit_count, total_byte_size
  );
endinterface

// File: rtl/get_bit.sv
// MSB-first bitstream unpacker: 64-bit left-justified buffer, byte intake,
// 0..32-bit field extraction on request and byte-align discard.
module get_bit (
  input  logic       clock,
  input  logic       reset_n,
  get_bit_if.slave   bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      r_state;
  logic [63:0] r_buf;
  logic [6:0]  r_bit_count;
  logic [5:0]  r_size;
  logic [31:0] r_total;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_val;

  logic [5:0]  w_sat;
  logic        w_ext;
  logic [5:0]  w_size;
  logic [6:0]  w_shamt;
  logic        w_acc;
  logic [6:0]  w_bc_rem;
  logic [63:0] w_buf_nxt;
  logic [6:0]  w_bc_nxt;
  logic [31:0] w_field;

  assign w_sat = (bus.req_size > 6'd32) ? 6'd32 : bus.req_size;
  assign w_acc = bus.in_valid & bus.in_ready;

  always_comb begin
    w_ext   = 1'b0;
    w_size  = 6'd0;
    w_shamt = 7'd0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if ({1'b0, w_sat} <= r_bit_count) begin
            w_ext  = 1'b1;
            w_size = w_sat;
          end
        end else if (bus.align) begin
          w_shamt = {4'd0, r_bit_count[2:0]};
        end
      end
      WAIT: begin
        if ({1'b0, r_size} <= r_bit_count) begin
          w_ext  = 1'b1;
          w_size = r_size;
        end
      end
      default: ;
    endcase
    if (w_ext) w_shamt = {1'b0, w_size};
  end

  // The incoming byte lands directly behind whatever survives this cycle's shift.
  assign w_bc_rem  = r_bit_count - w_shamt;
  assign w_buf_nxt = (r_buf << w_shamt) |
                     (w_acc ? ({bus.in_byte, 56'd0} >> w_bc_rem) : 64'd0);
  assign w_bc_nxt  = w_bc_rem + (w_acc ? 7'd8 : 7'd0);
  // Size 0 shifts by the full word and yields zero.
  assign w_field   = r_buf[63:32] >> (7'd32 - {1'b0, w_size});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_buf       <= 64'd0;
      r_bit_count <= 7'd0;
      r_size      <= 6'd0;
      r_total     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_val   <= 32'd0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_bit_count <= w_bc_nxt;
      r_total     <= r_total + (w_acc ? 32'd1 : 32'd0);
      r_rsp_valid <= w_ext;
      if (w_ext) r_rsp_val <= w_field;
      case (r_state)
        IDLE: if (bus.req_valid && !w_ext) begin
          r_state <= WAIT;
          r_size  <= w_sat;
        end
        WAIT: if (w_ext) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready        = (r_bit_count <= 7'd56);
  assign bus.req_ready       = (r_state == IDLE);
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_val         = r_rsp_val;
  assign bus.bit_count       = r_bit_count;
  assign bus.total_byte_size = r_total;

endmodule

// File: tb/tb_get_bit.sv
// Directed vector bench for get_bit: per-cycle stimulus records with expected
// outputs sampled 1 time unit after each rising edge.
module tb_get_bit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  get_bit_if bus();
  get_bit dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [7:0]  ib;
    logic        rq;
    logic [5:0]  rs;
    logic        al;
    logic        e_rv;
    logic [31:0] e_val;
    logic [6:0]  e_bc;
    logic        e_rr;
    logic        e_ir;
    logic [31:0] e_tot;
  } vec_t;

  function automatic vec_t v(input logic rst_n, input logic iv, input logic [7:0] ib,
                             input logic rq, input logic [5:0] rs, input logic al,
                             input logic e_rv, input logic [31:0] e_val, input logic [6:0] e_bc,
                             input logic e_rr, input logic e_ir, input logic [31:0] e_tot);
    vec_t t;
    t.rst_n = rst_n; t.iv = iv; t.ib = ib; t.rq = rq; t.rs = rs; t.al = al;
    t.e_rv = e_rv; t.e_val = e_val; t.e_bc = e_bc; t.e_rr = e_rr; t.e_ir = e_ir; t.e_tot = e_tot;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    reset_n       = t.rst_n;
    bus.in_valid  = t.iv;
    bus.in_byte   = t.ib;
    bus.req_valid = t.rq;
    bus.req_size  = t.rs;
    bus.align     = t.al;
    @(posedge clock);
    #1;
    check({nm, ".rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, t.e_rv});
    if (t.e_rv) check({nm, ".rsp_val"}, bus.rsp_val, t.e_val);
    check({nm, ".bit_count"}, {25'd0, bus.bit_count}, {25'd0, t.e_bc});
    check({nm, ".req_ready"}, {31'd0, bus.req_ready}, {31'd0, t.e_rr});
    check({nm, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, t.e_ir});
    check({nm, ".total"}, bus.total_byte_size, t.e_tot);
  endtask

  localparam int NV = 33;
  vec_t tbl[NV];

  initial begin
    bus.in_valid = 1'b0; bus.in_byte = 8'd0; bus.req_valid = 1'b0;
    bus.req_size = 6'd0; bus.align = 1'b0;

    //           rst iv ib     rq rs  al  rv val       bc  rr ir tot
    tbl[0]  = v(0, 0, 8'h00, 0, 0,  0,  0, 0,        0,  1, 1, 0);
    // reset while a request waits
    tbl[1]  = v(1, 1, 8'hAA, 0, 0,  0,  0, 0,        8,  1, 1, 1);
    tbl[2]  = v(1, 0, 8'h00, 1, 16, 0,  0, 0,        8,  0, 1, 1);
    tbl[3]  = v(1, 0, 8'h00, 0, 0,  0,  0, 0,        8,  0, 1, 1);
    tbl[4]  = v(0, 0, 8'h00, 0, 0,  0,  0, 0,        0,  1, 1, 0);
    tbl[5]  = v(1, 0, 8'h00, 0, 0,  0,  0, 0,        0,  1, 1, 0);
    // A5 3C split 3/5/4/4
    tbl[6]  = v(1, 1, 8'hA5, 0, 0,  0,  0, 0,        8,  1, 1, 1);
    tbl[7]  = v(1, 1, 8'h3C, 0, 0,  0,  0, 0,        16, 1, 1, 2);
    tbl[8]  = v(1, 0, 8'h00, 1, 3,  0,  1, 32'h5,    13, 1, 1, 2);
    tbl[9]  = v(1, 0, 8'h00, 1, 5,  0,  1, 32'h5,    8,  1, 1, 2);
    tbl[10] = v(1, 0, 8'h00, 1, 4,  0,  1, 32'h3,    4,  1, 1, 2);
    tbl[11] = v(1, 0, 8'h00, 1, 4,  0,  1, 32'hC,    0,  1, 1, 2);
    tbl[12] = v(1, 0, 8'h00, 0, 0,  0,  0, 0,        0,  1, 1, 2);
    // S=12 from empty, bytes two cycles apart
    tbl[13] = v(1, 0, 8'h00, 1, 12, 0,  0, 0,        0,  0, 1, 2);
    tbl[14] = v(1, 1, 8'hFF, 0, 0,  0,  0, 0,        8,  0, 1, 3);
    tbl[15] = v(1, 0, 8'h00, 0, 0,  0,  0, 0,        8,  0, 1, 3);
    tbl[16] = v(1, 1, 8'h0F, 0, 0,  0,  0, 0,        16, 0, 1, 4);
    tbl[17] = v(1, 0, 8'h00, 0, 0,  0,  1, 32'hFF0,  4,  1, 1, 4);
    tbl[18] = v(1, 0, 8'h00, 0, 0,  1,  0, 0,        0,  1, 1, 4);
    // align after partial consume
    tbl[19] = v(1, 1, 8'h80, 0, 0,  0,  0, 0,        8,  1, 1, 5);
    tbl[20] = v(1, 0, 8'h00, 1, 1,  0,  1, 32'h1,    7,  1, 1, 5);
    tbl[21] = v(1, 0, 8'h00, 0, 0,  1,  0, 0,        0,  1, 1, 5);
    tbl[22] = v(1, 1, 8'h40, 0, 0,  0,  0, 0,        8,  1, 1, 6);
    tbl[23] = v(1, 0, 8'h00, 1, 2,  0,  1, 32'h1,    6,  1, 1, 6);
    tbl[24] = v(1, 0, 8'h00, 0, 0,  1,  0, 0,        0,  1, 1, 6);
    // aligned align is a no-op; request beats align
    tbl[25] = v(1, 1, 8'hC3, 0, 0,  0,  0, 0,        8,  1, 1, 7);
    tbl[26] = v(1, 0, 8'h00, 0, 0,  1,  0, 0,        8,  1, 1, 7);
    tbl[27] = v(1, 0, 8'h00, 1, 2,  1,  1, 32'h3,    6,  1, 1, 7);
    tbl[28] = v(1, 0, 8'h00, 1, 6,  0,  1, 32'h3,    0,  1, 1, 7);
    // intake and extraction in the same cycle
    tbl[29] = v(1, 1, 8'h96, 0, 0,  0,  0, 0,        8,  1, 1, 8);
    tbl[30] = v(1, 1, 8'h5A, 1, 4,  0,  1, 32'h9,    12, 1, 1, 9);
    tbl[31] = v(1, 0, 8'h00, 1, 12, 0,  1, 32'h65A,  0,  1, 1, 9);
    tbl[32] = v(1, 0, 8'h00, 1, 0,  0,  1, 32'h0,    0,  1, 1, 9);

    for (int i = 0; i < NV; i++) step(tbl[i], $sformatf("v%0d", i));

    // Fill to 64 bits, in_ready low, held byte refused, then two 32-bit fields.
    step(v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0), "s_rst");
    for (int k = 1; k <= 7; k++)
      step(v(1, 1, 8'(k), 0, 0, 0, 0, 0, 7'(8 * k), 1, 1, 32'(k)), $sformatf("s_b%0d", k));
    step(v(1, 1, 8'h08, 0, 0,  0, 0, 0,            64, 1, 0, 8), "s_b8");
    step(v(1, 1, 8'h99, 1, 32, 0, 1, 32'h01020304, 32, 1, 1, 8), "s_r1");
    step(v(1, 0, 8'h00, 1, 32, 0, 1, 32'h05060708, 0,  1, 1, 8), "s_r2");

    // S=0 leaves the buffer alone, S=40 saturates to 32.
    step(v(0, 0, 8'h00, 0, 0,  0, 0, 0,            0,  1, 1, 0), "d_rst");
    step(v(1, 1, 8'hDE, 0, 0,  0, 0, 0,            8,  1, 1, 1), "d_b0");
    step(v(1, 1, 8'hAD, 0, 0,  0, 0, 0,            16, 1, 1, 2), "d_b1");
    step(v(1, 1, 8'hBE, 0, 0,  0, 0, 0,            24, 1, 1, 3), "d_b2");
    step(v(1, 1, 8'hEF, 0, 0,  0, 0, 0,            32, 1, 1, 4), "d_b3");
    step(v(1, 0, 8'h00, 1, 0,  0, 1, 32'h0,        32, 1, 1, 4), "d_s0");
    step(v(1, 0, 8'h00, 1, 40, 0, 1, 32'hDEADBEEF, 0,  1, 1, 4), "d_s40");
    step(v(1, 0, 8'h00, 0, 0,  0, 0, 0,            0,  1, 1, 4), "d_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
